// File: rtl/glitch_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : glitch_filter_pkg
// Brief   : Shared constants and width helper for the glitch filter.
// Revision: 1.0 - initial release
// ============================================================================
package glitch_filter_pkg;

  // Stability length that disables filtering entirely.
  localparam int LEN_BYPASS = 0;

  // Bits needed to hold the values 0..maxlen.
  function automatic int cw_of(input int maxlen);
    int w;
    w = 1;
    while ((1 << w) < (maxlen + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/glitch_filter_bit.sv
`default_nettype none
// ============================================================================
// Module  : glitch_filter_bit
// Brief   : One filtered channel: candidate value, run counter, output bit.
// Revision: 1.0 - initial release
// ============================================================================
module glitch_filter_bit
  import glitch_filter_pkg::*;
#(
  parameter int MAXLEN = 15,
  parameter int CW     = cw_of(MAXLEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          xfer_i,
  input  logic          ena_i,
  input  logic          bypass_i,
  input  logic [CW-1:0] len_i,
  input  logic          din_i,
  output logic          dout_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAXLEN);

  logic          cand_q, cand_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          dout_q, dout_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (xfer_i) begin
      if (!ena_i) begin
        // Preload a saturated run so re-enabling never delays the current level.
        cand_d = din_i;
        cnt_d  = CNT_MAX;
        dout_d = din_i;
      end else begin
        if (din_i == cand_q) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else begin
          cand_d = din_i;
          cnt_d  = '0;
        end
        if (bypass_i || (cnt_d >= len_i)) begin
          dout_d = din_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= 1'b0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule
`default_nettype wire

// File: rtl/glitch_filter.sv
`default_nettype none
// ============================================================================
// Module  : glitch_filter
// Brief   : Per-bit glitch filter on a valid/ready stream with one-deep output register.
// Revision: 1.0 - initial release
// ============================================================================
module glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter  int SDW    = 32,
  parameter  int MAXLEN = 15,
  localparam int CW     = cw_of(MAXLEN)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [CW-1:0]  cfg_len,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [SDW-1:0] sto_tdata
);

  localparam logic [CW-1:0] LEN_MAX = CW'(MAXLEN);
  localparam logic [CW-1:0] LEN_BYP = CW'(LEN_BYPASS);

  logic          sto_tvalid_q;
  logic          xfer;
  logic [CW-1:0] len_eff;
  logic          len_bypass;

  assign sti_tready = sto_tready | ~sto_tvalid_q;
  assign xfer       = sti_tvalid & sti_tready;
  assign len_eff    = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign len_bypass = (len_eff == LEN_BYP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sto_tvalid_q <= 1'b0;
    end else if (sti_tready) begin
      sto_tvalid_q <= sti_tvalid;
    end
  end

  assign sto_tvalid = sto_tvalid_q;

  generate
    for (genvar i = 0; i < SDW; i++) begin : g_bit
      glitch_filter_bit #(
        .MAXLEN (MAXLEN),
        .CW     (CW)
      ) u_bit (
        .clk      (clk),
        .rst      (rst),
        .xfer_i   (xfer),
        .ena_i    (ena),
        .bypass_i (len_bypass),
        .len_i    (len_eff),
        .din_i    (sti_tdata[i]),
        .dout_o   (sto_tdata[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_glitch_filter.sv
`default_nettype none
// ============================================================================
// Module  : tb_glitch_filter
// Brief   : Directed and randomized checks of glitch_filter against a run-length model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_glitch_filter;

  localparam int SDW    = 4;
  localparam int MAXLEN = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic [3:0]     cfg_len;
  logic           sti_tready;
  logic           sti_tvalid;
  logic [SDW-1:0] sti_tdata;
  logic           sto_tready;
  logic           sto_tvalid;
  logic [SDW-1:0] sto_tdata;

  int checks = 0;
  int errors = 0;

  // Model: each bit remembers the value of its current run and how many
  // consecutive equal samples that run holds; an edge passes once the run
  // reaches L+1 samples.
  logic           m_valid;
  logic [SDW-1:0] m_data;
  logic           run_val [SDW];
  int             run_len [SDW];

  glitch_filter #(
    .SDW    (SDW),
    .MAXLEN (MAXLEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .cfg_len    (cfg_len),
    .sti_tready (sti_tready),
    .sti_tvalid (sti_tvalid),
    .sti_tdata  (sti_tdata),
    .sto_tready (sto_tready),
    .sto_tvalid (sto_tvalid),
    .sto_tdata  (sto_tdata)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    for (int i = 0; i < SDW; i++) begin
      run_val[i] = 1'b0;
      run_len[i] = 1;
    end
  endtask

  task automatic model_edge();
    logic rdy;
    int   l;
    rdy = sto_tready | !m_valid;
    l   = (int'(cfg_len) > MAXLEN) ? MAXLEN : int'(cfg_len);
    if (sti_tvalid && rdy) begin
      for (int i = 0; i < SDW; i++) begin
        if (!ena) begin
          run_val[i] = sti_tdata[i];
          run_len[i] = 1000;
          m_data[i]  = sti_tdata[i];
        end else begin
          if (sti_tdata[i] == run_val[i]) begin
            if (run_len[i] < 1000) run_len[i] = run_len[i] + 1;
          end else begin
            run_val[i] = sti_tdata[i];
            run_len[i] = 1;
          end
          if (run_len[i] >= l + 1) m_data[i] = sti_tdata[i];
        end
      end
    end
    if (rdy) m_valid = sti_tvalid;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    sti_tvalid = 1'b0;
    sti_tdata  = '0;
    sto_tready = 1'b1;
    ena        = 1'b1;
    cfg_len    = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input logic [3:0] d, input logic [3:0] l, input logic en);
    sti_tvalid = 1'b1;
    sti_tdata  = d;
    cfg_len    = l;
    ena        = en;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (sto_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", sto_tvalid);
    end
    checks++;
    if (sto_tdata !== 4'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", sto_tdata);
    end
    checks++;
    if (sti_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", sti_tready);
    end
    do_reset();
  endtask

  task automatic test_len0();
    logic [3:0] pat [3];
    pat[0] = 4'h0; pat[1] = 4'hF; pat[2] = 4'h0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(pat[k], 4'd0, 1'b1);
      checks++;
      if (sto_tdata !== pat[k] || sto_tvalid !== 1'b1) begin
        errors++;
        $display("FAIL len0 sample %0d: got %h/%b expected %h/1", k, sto_tdata, sto_tvalid, pat[k]);
      end
    end
  endtask

  task automatic test_len1();
    logic [3:0] pat [4];
    pat[0] = 4'h0; pat[1] = 4'h1; pat[2] = 4'h0; pat[3] = 4'h0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(pat[k], 4'd1, 1'b1);
      checks++;
      if (sto_tdata !== 4'h0) begin
        errors++;
        $display("FAIL len1 sample %0d: got %h expected 0", k, sto_tdata);
      end
    end
  endtask

  task automatic test_len3();
    logic [3:0] pat [5];
    logic       exp [5];
    pat[0] = 4'h0; pat[1] = 4'h1; pat[2] = 4'h1; pat[3] = 4'h1; pat[4] = 4'h1;
    exp[0] = 1'b0; exp[1] = 1'b0; exp[2] = 1'b0; exp[3] = 1'b0; exp[4] = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(pat[k], 4'd3, 1'b1);
      checks++;
      if (sto_tdata[0] !== exp[k]) begin
        errors++;
        $display("FAIL len3 sample %0d: got %b expected %b", k, sto_tdata[0], exp[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(4'hF, 4'd2, 1'b1);
    sto_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (sti_tready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready cycle %0d: got %b expected 0", k, sti_tready);
      end
      @(posedge clk);
      model_edge();
      #1;
      checks++;
      if (sto_tdata !== 4'h0 || sto_tvalid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: got %h/%b expected 0/1", k, sto_tdata, sto_tvalid);
      end
    end
    sto_tready = 1'b1;
    step(4'hF, 4'd2, 1'b1);
    checks++;
    if (sto_tdata !== 4'h0) begin
      errors++;
      $display("FAIL stall_run2: got %h expected 0", sto_tdata);
    end
    step(4'hF, 4'd2, 1'b1);
    checks++;
    if (sto_tdata !== 4'hF) begin
      errors++;
      $display("FAIL stall_run3: got %h expected f", sto_tdata);
    end
  endtask

  task automatic test_reset_midrun();
    logic [3:0] exp [4];
    exp[0] = 4'h0; exp[1] = 4'h0; exp[2] = 4'h0; exp[3] = 4'hF;
    do_reset();
    step(4'hF, 4'd3, 1'b0);
    step(4'hF, 4'd3, 1'b1);
    step(4'hF, 4'd3, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if (sto_tvalid !== 1'b0 || sto_tdata !== 4'h0) begin
      errors++;
      $display("FAIL midrun_reset: got %h/%b expected 0/0", sto_tdata, sto_tvalid);
    end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 4'd3, 1'b1);
      checks++;
      if (sto_tdata !== exp[k]) begin
        errors++;
        $display("FAIL midrun_rerun sample %0d: got %h expected %h", k, sto_tdata, exp[k]);
      end
    end
  endtask

  task automatic test_reenable();
    logic [3:0] pat [6];
    logic [3:0] exp [6];
    pat[0] = 4'h5; pat[1] = 4'h5; pat[2] = 4'h5; pat[3] = 4'hA; pat[4] = 4'hA; pat[5] = 4'hA;
    exp[0] = 4'h5; exp[1] = 4'h5; exp[2] = 4'h5; exp[3] = 4'h5; exp[4] = 4'h5; exp[5] = 4'hA;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(pat[k], 4'd2, (k != 0));
      checks++;
      if (sto_tdata !== exp[k]) begin
        errors++;
        $display("FAIL reenable sample %0d: got %h expected %h", k, sto_tdata, exp[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] d;
    do_reset();
    d = '0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom % 200 == 0) begin
        rst = 1'b1;
        #1;
        checks++;
        if (sto_tvalid !== 1'b0 || sto_tdata !== 4'h0) begin
          errors++;
          $display("FAIL rnd_reset cycle %0d: got %h/%b expected 0/0", n, sto_tdata, sto_tvalid);
        end
        do_reset();
      end
      if ($urandom % 4 == 0) d = 4'($urandom);
      else if ($urandom % 3 == 0) d = d ^ 4'(1 << ($urandom % 4));
      sti_tdata  = d;
      sti_tvalid = ($urandom % 4) != 0;
      sto_tready = ($urandom % 4) != 0;
      ena        = ($urandom % 10) != 0;
      if ($urandom % 30 == 0) cfg_len = 4'($urandom % 16);
      #1;
      checks++;
      if (sti_tready !== (sto_tready | !m_valid)) begin
        errors++;
        $display("FAIL rnd_ready cycle %0d: got %b expected %b", n, sti_tready, sto_tready | !m_valid);
      end
      @(posedge clk);
      model_edge();
      #1;
      checks++;
      if (sto_tvalid !== m_valid || sto_tdata !== m_data) begin
        errors++;
        $display("FAIL rnd_out cycle %0d: got %h/%b expected %h/%b", n, sto_tdata, sto_tvalid, m_data, m_valid);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    ena        = 1'b1;
    cfg_len    = '0;
    sti_tvalid = 1'b0;
    sti_tdata  = '0;
    sto_tready = 1'b1;
    model_reset();
    test_reset();
    test_len0();
    test_len1();
    test_len3();
    test_backpressure();
    test_reset_midrun();
    test_reenable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glitch_filter.md
GLITCH_FILTER -- requirements
Module: glitch_filter

Interface
REQ-001 Parameter SDW, default 32, sample data width (number of independent filtered channels).
REQ-002 Parameter MAXLEN, default 15, maximum programmable glitch length in samples; CW = ceil(log2(MAXLEN+1)) is the derived counter width.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ena  input  1  filter enable; 0 = transparent bypass.
REQ-006 cfg_len  input  CW  required stability length L; 0 = bypass, values above MAXLEN are clamped to MAXLEN.
REQ-007 sti_tready  output  1  input stream ready.
REQ-008 sti_tvalid  input  1  input stream valid.
REQ-009 sti_tdata  input  SDW  input stream sample.
REQ-010 sto_tready  input  1  output stream ready.
REQ-011 sto_tvalid  output  1  output stream valid, registered.
REQ-012 sto_tdata  output  SDW  filtered sample, registered.

Function
REQ-013 A transfer occurs when sti_tvalid and sti_tready are both 1; all filter state advances only on transfers.
REQ-014 sti_tready = sto_tready | ~sto_tvalid, combinationally; no other path from input to output.
REQ-015 When sti_tready = 1, sto_tvalid loads sti_tvalid on the next edge; when sti_tready = 0, sto_tvalid and sto_tdata hold.
REQ-016 Per bit i: candidate cand[i] (1 bit) and run counter cnt[i] (CW bits) are kept.
REQ-017 On a transfer with ena = 1: if sti_tdata[i] == cand[i], cnt[i] increments, saturating at MAXLEN; otherwise cand[i] loads sti_tdata[i] and cnt[i] loads 0.
REQ-018 On a transfer with ena = 1: sto_tdata[i] loads sti_tdata[i] when the updated cnt[i] >= L; otherwise it holds. Result: an input edge reaches the output only after L+1 consecutive equal samples.
REQ-019 L = 1 rejects exactly single-sample glitches; L = 0 passes every sample.
REQ-020 Latency: a sample that satisfies REQ-018 appears on sto_tdata one clock after its transfer.
REQ-021 On a transfer with ena = 0: sto_tdata loads sti_tdata for all bits, cand loads sti_tdata, and cnt loads MAXLEN, so re-enabling causes no spurious delay or glitch.
REQ-022 cfg_len and ena are sampled on every transfer; a change takes effect on the next transfer with no flush, and existing cnt values are compared against the new L.
REQ-023 Simultaneous change of several bits in one sample: each bit is filtered independently; no cross-bit coupling.
REQ-024 Backpressure (sto_tready = 0, sto_tvalid = 1): cand, cnt and sto_tdata freeze, and no sample is lost or duplicated.

Reset
REQ-025 While rst = 1: sto_tvalid = 0, sto_tdata = 0, cand = 0 and cnt = 0 for all bits, taking effect immediately and independent of clk.
REQ-026 Reset mid-run discards partial runs; after release, a 1 on any bit needs a full L+1 run before it appears on the output.
REQ-027 sti_tready = 1 whenever rst = 1 (follows from sto_tvalid = 0).

Structure
REQ-028 Shared package glitch_filter_pkg holds the CW width helper function and the bypass encoding constant (L = 0).
REQ-029 A single sub-module glitch_filter_bit, instantiated SDW times, holds cand, cnt and one sto_tdata bit; the top level holds the handshake, sto_tvalid, and the clamping of cfg_len.
REQ-030 No combinational path other than sto_tready/sto_tvalid to sti_tready.

Verification (SDW = 4, MAXLEN = 15, sto_tready = 1 unless stated)
REQ-031 ena = 1, L = 0, input 0x0, 0xF, 0x0 -> sto_tdata 0x0, 0xF, 0x0, each one cycle after its transfer.
REQ-032 L = 1, input 0x0, 0x1, 0x0, 0x0 -> sto_tdata remains 0x0 for all four samples.
REQ-033 L = 3, bit0 input 0, 1, 1, 1, 1 -> sto_tdata[0] 0, 0, 0, 0, 1 (rises on the fourth consecutive 1).
REQ-034 L = 2, sto_tready = 0 for 5 cycles mid-run -> sti_tready = 0, sto_tdata and cnt frozen; after release the run completes with the same sample count as without the stall.
REQ-035 L = 3, rst pulsed after two samples of 0xF -> sto_tvalid = 0 and sto_tdata = 0x0 immediately; after release, four samples of 0xF are needed before sto_tdata = 0xF.
REQ-036 ena = 0, input 0x5 -> sto_tdata = 0x5; then ena = 1, L = 2, input held at 0x5 then 0x5, 0xA -> output stays 0x5 with no dropout, and 0xA is suppressed until three consecutive samples of 0xA.
